// File: rtl/integral_image_builder.sv
// Integral-image builder: consumes one raster-ordered pixel window, accumulates its
// integral image into a flat register buffer, then holds it under START until acknowledged.
module integral_image_builder #(
    parameter int WIN_W = 20,
    parameter int WIN_H = 20,
    parameter int PIX_W = 8,
    parameter int II_W  = 32
) (
    input  logic                        Clk,
    input  logic                        Reset_n,
    input  logic [PIX_W-1:0]            pix_data,
    input  logic                        pix_valid,
    input  logic                        pix_sof,
    output logic                        pix_ready,
    input  logic                        frame_ack,
    output logic                        START,
    output logic [WIN_W*WIN_H*II_W-1:0] integral_buffer,
    output logic                        busy,
    output logic                        sof_err
);
    localparam int N     = WIN_W * WIN_H;
    localparam int IDX_W = $clog2(N);
    localparam int X_W   = $clog2(WIN_W);
    localparam int Y_W   = $clog2(WIN_H);
    localparam logic [X_W-1:0]   X_LAST     = X_W'(WIN_W - 1);
    localparam logic [Y_W-1:0]   Y_LAST     = Y_W'(WIN_H - 1);
    localparam logic [IDX_W-1:0] ROW_STRIDE = IDX_W'(WIN_W);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [X_W-1:0]   r_x;
    logic [Y_W-1:0]   r_y;
    logic [IDX_W-1:0] r_idx;
    logic [II_W-1:0]  r_rowsum;
    logic [II_W-1:0]  r_buf [N];
    logic             r_start;
    logic             r_busy;
    logic             r_sof_err;
    logic             r_pix_ready;

    logic [X_W-1:0]   w_x_nxt;
    logic [Y_W-1:0]   w_y_nxt;
    logic [IDX_W-1:0] w_idx_nxt;
    logic [II_W-1:0]  w_rowsum_nxt;
    logic             w_wr_en;
    logic             w_sof_err_nxt;

    logic             w_accept;
    logic             w_restart;
    logic [X_W-1:0]   w_x_eff;
    logic [Y_W-1:0]   w_y_eff;
    logic [IDX_W-1:0] w_idx_eff;
    logic [II_W-1:0]  w_pix_ext;
    logic [II_W-1:0]  w_rowsum_new;
    logic [IDX_W-1:0] w_above_idx;
    logic [II_W-1:0]  w_above;
    logic [II_W-1:0]  w_ii;
    logic             w_last_x;
    logic             w_last;
    logic [X_W-1:0]   w_adv_x;
    logic [Y_W-1:0]   w_adv_y;
    logic [IDX_W-1:0] w_adv_idx;

    // Integral arithmetic for the pixel on the bus; a pixel outside ACCUM or with sof lands at (0,0).
    always_comb begin
        w_accept  = pix_valid & r_pix_ready;
        w_restart = (r_state != ST_ACCUM) | pix_sof;
        w_pix_ext = {{(II_W-PIX_W){1'b0}}, pix_data};
        if (w_restart) begin
            w_x_eff   = {X_W{1'b0}};
            w_y_eff   = {Y_W{1'b0}};
            w_idx_eff = {IDX_W{1'b0}};
        end else begin
            w_x_eff   = r_x;
            w_y_eff   = r_y;
            w_idx_eff = r_idx;
        end
        if (w_x_eff == {X_W{1'b0}}) begin
            w_rowsum_new = w_pix_ext;
        end else begin
            w_rowsum_new = r_rowsum + w_pix_ext;
        end
        if (w_y_eff == {Y_W{1'b0}}) begin
            w_above_idx = {IDX_W{1'b0}};
            w_above     = {II_W{1'b0}};
        end else begin
            w_above_idx = w_idx_eff - ROW_STRIDE;
            w_above     = r_buf[w_above_idx];
        end
        w_ii     = w_rowsum_new + w_above;
        w_last_x = (w_x_eff == X_LAST);
        w_last   = w_last_x & (w_y_eff == Y_LAST);
        if (w_last_x) begin
            w_adv_x = {X_W{1'b0}};
            if (w_last) begin
                w_adv_y = {Y_W{1'b0}};
            end else begin
                w_adv_y = w_y_eff + Y_W'(1);
            end
        end else begin
            w_adv_x = w_x_eff + X_W'(1);
            w_adv_y = w_y_eff;
        end
        if (w_last) begin
            w_adv_idx = {IDX_W{1'b0}};
        end else begin
            w_adv_idx = w_idx_eff + IDX_W'(1);
        end
    end

    // Next-state and position/row-sum update selection.
    always_comb begin
        w_state_nxt   = r_state;
        w_x_nxt       = r_x;
        w_y_nxt       = r_y;
        w_idx_nxt     = r_idx;
        w_rowsum_nxt  = r_rowsum;
        w_wr_en       = 1'b0;
        w_sof_err_nxt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept && pix_sof) begin
                    w_wr_en      = 1'b1;
                    w_x_nxt      = w_adv_x;
                    w_y_nxt      = w_adv_y;
                    w_idx_nxt    = w_adv_idx;
                    w_rowsum_nxt = w_rowsum_new;
                    w_state_nxt  = w_last ? ST_DONE : ST_ACCUM;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ACCUM: begin
                if (w_accept) begin
                    w_wr_en       = 1'b1;
                    w_sof_err_nxt = pix_sof;
                    w_x_nxt       = w_adv_x;
                    w_y_nxt       = w_adv_y;
                    w_idx_nxt     = w_adv_idx;
                    w_rowsum_nxt  = w_rowsum_new;
                    w_state_nxt   = w_last ? ST_DONE : ST_ACCUM;
                end else begin
                    w_state_nxt = ST_ACCUM;
                end
            end
            ST_DONE: begin
                if (frame_ack) begin
                    w_state_nxt = ST_IDLE;
                    w_x_nxt     = {X_W{1'b0}};
                    w_y_nxt     = {Y_W{1'b0}};
                    w_idx_nxt   = {IDX_W{1'b0}};
                end else begin
                    w_state_nxt = ST_DONE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_x_nxt     = {X_W{1'b0}};
                w_y_nxt     = {Y_W{1'b0}};
                w_idx_nxt   = {IDX_W{1'b0}};
            end
        endcase
    end

    // State, position and row-sum registers.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state  <= ST_IDLE;
            r_x      <= {X_W{1'b0}};
            r_y      <= {Y_W{1'b0}};
            r_idx    <= {IDX_W{1'b0}};
            r_rowsum <= {II_W{1'b0}};
        end else begin
            r_state  <= w_state_nxt;
            r_x      <= w_x_nxt;
            r_y      <= w_y_nxt;
            r_idx    <= w_idx_nxt;
            r_rowsum <= w_rowsum_nxt;
        end
    end

    // Status outputs are registered from the next state so they line up with r_state.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_start     <= 1'b0;
            r_busy      <= 1'b0;
            r_sof_err   <= 1'b0;
            r_pix_ready <= 1'b0;
        end else begin
            r_start     <= (w_state_nxt == ST_DONE);
            r_busy      <= (w_state_nxt == ST_ACCUM);
            r_sof_err   <= w_sof_err_nxt;
            r_pix_ready <= (w_state_nxt != ST_DONE);
        end
    end

    // Integral buffer: one entry written per processed pixel, cleared only by reset.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < N; i++) begin
                r_buf[i] <= {II_W{1'b0}};
            end
        end else if (w_wr_en) begin
            r_buf[w_idx_eff] <= w_ii;
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_flat
        assign integral_buffer[g*II_W +: II_W] = r_buf[g];
    end

    assign pix_ready = r_pix_ready;
    assign START     = r_start;
    assign busy      = r_busy;
    assign sof_err   = r_sof_err;

endmodule

// File: tb/tb_integral_image_builder.sv
// Self-checking bench for integral_image_builder: directed and random frames compared
// against a brute-force rectangle-sum model, plus handshake and reset corner cases.
module tb_integral_image_builder;
    localparam int W   = 20;
    localparam int H   = 20;
    localparam int N   = W * H;
    localparam int IIW = 32;

    logic           Clk       = 1'b0;
    logic           Reset_n   = 1'b1;
    logic [7:0]     pix_data  = 8'd0;
    logic           pix_valid = 1'b0;
    logic           pix_sof   = 1'b0;
    logic           frame_ack = 1'b0;
    logic           pix_ready;
    logic           START;
    logic           busy;
    logic           sof_err;
    logic [N*IIW-1:0] integral_buffer;

    int          errors = 0;
    int          checks = 0;
    int          sof_err_cnt = 0;
    int          frame_pix [N];
    logic [31:0] exp_ii [N];
    bit          start_before;

    typedef struct {
        int          mode;
        int          idx;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs [12];

    integral_image_builder dut (
        .Clk             (Clk),
        .Reset_n         (Reset_n),
        .pix_data        (pix_data),
        .pix_valid       (pix_valid),
        .pix_sof         (pix_sof),
        .pix_ready       (pix_ready),
        .frame_ack       (frame_ack),
        .START           (START),
        .integral_buffer (integral_buffer),
        .busy            (busy),
        .sof_err         (sof_err)
    );

    always #5 Clk = ~Clk;

    always @(negedge Clk) begin
        if (sof_err === 1'b1) sof_err_cnt++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // mode 0: ones, 1: 255, 2: ramp p=x, 3: random
    task automatic build_frame(input int mode);
        longint s;
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                case (mode)
                    0: frame_pix[y*W+x] = 1;
                    1: frame_pix[y*W+x] = 255;
                    2: frame_pix[y*W+x] = x;
                    default: frame_pix[y*W+x] = int'($urandom_range(0, 255));
                endcase
            end
        end
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                s = 0;
                for (int j = 0; j <= y; j++)
                    for (int i = 0; i <= x; i++)
                        s += frame_pix[j*W+i];
                exp_ii[y*W+x] = s[31:0];
            end
        end
    endtask

    task automatic check_buf(input string name, input bit zero);
        int bad;
        int first;
        logic [31:0] req;
        logic [31:0] act;
        logic [31:0] act_first;
        logic [31:0] req_first;
        bad = 0;
        first = -1;
        act_first = 32'd0;
        req_first = 32'd0;
        for (int i = 0; i < N; i++) begin
            req = zero ? 32'd0 : exp_ii[i];
            act = integral_buffer[i*IIW +: IIW];
            if (act !== req) begin
                if (first < 0) begin
                    first = i;
                    act_first = act;
                    req_first = req;
                end
                bad++;
            end
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL %s: %0d bad entries, first idx %0d got %0d expected %0d",
                     name, bad, first, act_first, req_first);
        end
    endtask

    task automatic send_pixel(input int data, input bit sof, input int gap_max);
        int n;
        int waitc;
        n = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
        pix_valid = 1'b0;
        repeat (n) @(posedge Clk);
        #1;
        pix_valid = 1'b1;
        pix_data  = data[7:0];
        pix_sof   = sof;
        waitc = 0;
        forever begin
            @(negedge Clk);
            start_before = START;
            if (pix_ready === 1'b1) begin
                @(posedge Clk);
                #1;
                break;
            end
            @(posedge Clk);
            waitc++;
            if (waitc > 1000) begin
                check("accept_timeout", 32'd1, 32'd0);
                break;
            end
        end
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
    endtask

    task automatic send_frame(input int gap_max, input int first);
        for (int i = first; i < N; i++) begin
            send_pixel(frame_pix[i], (i == 0), gap_max);
        end
        check("start_latency", {30'd0, start_before, START}, 32'd1);
    endtask

    task automatic check_vecs(input int mode);
        for (int k = 0; k < 12; k++) begin
            if (vecs[k].mode == mode) begin
                check($sformatf("vec_m%0d_idx%0d", mode, vecs[k].idx),
                      integral_buffer[vecs[k].idx*IIW +: IIW], vecs[k].exp);
            end
        end
    endtask

    task automatic ack_frame(input int hold);
        int bad;
        bad = 0;
        repeat (hold) begin
            @(negedge Clk);
            if (START !== 1'b1) bad++;
        end
        check("start_hold", bad, 0);
        @(posedge Clk);
        #1;
        frame_ack = 1'b1;
        @(posedge Clk);
        #1;
        frame_ack = 1'b0;
        check("ack_start_low", {31'd0, START}, 32'd0);
        check("ack_ready_high", {31'd0, pix_ready}, 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_start"}, {31'd0, START}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_sof_err"}, {31'd0, sof_err}, 32'd0);
        check({tag, "_ready"}, {31'd0, pix_ready}, 32'd0);
        check_buf({tag, "_buf"}, 1'b1);
    endtask

    initial begin
        int bad;
        int cnt0;
        vecs[0]  = '{0, 0,   32'd1};
        vecs[1]  = '{0, 19,  32'd20};
        vecs[2]  = '{0, 21,  32'd4};
        vecs[3]  = '{0, 210, 32'd121};
        vecs[4]  = '{0, 399, 32'd400};
        vecs[5]  = '{1, 0,   32'd255};
        vecs[6]  = '{1, 19,  32'd5100};
        vecs[7]  = '{1, 380, 32'd5100};
        vecs[8]  = '{1, 399, 32'd102000};
        vecs[9]  = '{2, 19,  32'd190};
        vecs[10] = '{2, 39,  32'd380};
        vecs[11] = '{2, 399, 32'd3800};

        // reset state
        #1 Reset_n = 1'b0;
        #2 check_reset_outputs("reset");
        @(negedge Clk);
        Reset_n = 1'b1;
        @(posedge Clk);
        #1;
        check("release_ready", {31'd0, pix_ready}, 32'd1);
        check("release_busy", {31'd0, busy}, 32'd0);

        // table-driven frames: ones, 255, ramp
        for (int m = 0; m < 3; m++) begin
            build_frame(m);
            send_frame(0, 0);
            check_buf($sformatf("frame_m%0d", m), 1'b0);
            check_vecs(m);
            ack_frame((m == 2) ? 5 : 0);
        end

        // gaps, then pix_valid held through DONE and across the ack
        build_frame(0);
        send_frame(3, 0);
        check_buf("gap_frame", 1'b0);
        pix_data = 8'd77;
        pix_sof = 1'b0;
        pix_valid = 1'b1;
        bad = 0;
        repeat (5) begin
            @(negedge Clk);
            if (pix_ready !== 1'b0 || START !== 1'b1) bad++;
        end
        check("done_no_accept", bad, 0);
        check_buf("done_frozen", 1'b0);
        @(posedge Clk);
        #1;
        frame_ack = 1'b1;
        @(posedge Clk);
        #1;
        frame_ack = 1'b0;
        check("ack_with_valid_start", {31'd0, START}, 32'd0);
        @(posedge Clk);
        #1;
        pix_valid = 1'b0;
        check("idle_drop_after_ack", {31'd0, busy}, 32'd0);

        // leading sof=0 pixels dropped, then sof reasserted mid-frame
        build_frame(0);
        for (int k = 0; k < 3; k++) send_pixel(99, 1'b0, 0);
        check("idle_drop_busy", {31'd0, busy}, 32'd0);
        for (int i = 0; i < 150; i++) send_pixel(1, (i == 0), 0);
        check("mid_frame_busy", {31'd0, busy}, 32'd1);
        cnt0 = sof_err_cnt;
        send_pixel(frame_pix[0], 1'b1, 0);
        check("sof_err_pulse", {31'd0, sof_err}, 32'd1);
        send_frame(0, 1);
        check("sof_err_count", sof_err_cnt - cnt0, 1);
        check_buf("restart_frame", 1'b0);
        ack_frame(0);

        // asynchronous reset mid-frame
        build_frame(0);
        for (int i = 0; i < 200; i++) send_pixel(1, (i == 0), 0);
        #2 Reset_n = 1'b0;
        #1 check_reset_outputs("midreset");
        @(negedge Clk);
        Reset_n = 1'b1;
        @(posedge Clk);
        #1;
        send_frame(0, 0);
        check_buf("post_reset_frame", 1'b0);
        check_vecs(0);
        ack_frame(0);

        // random pixels with random gaps
        for (int f = 0; f < 2; f++) begin
            build_frame(3);
            send_frame(2, 0);
            check_buf($sformatf("random_frame%0d", f), 1'b0);
            ack_frame(1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
